tlb_ctrl: RTL and testbench

Sequencer for the 32-entry TLB maintenance port: probe (search), indexed read, indexed write and random write.
- Accepts one command at a time from the CPU control path over a valid/ready handshake.
- Drives the TLB rw_index / w_enable / w_page / w_frame / page_in pins, captures results and returns a single response.
- Owns the random-replacement index counter.
- Asserts a lock to freeze instruction-fetch translation while a TLB write is in progress.

---
 rtl/tlb_ctrl_if.sv | 28 ++
 rtl/tlb_ctrl.sv | 156 +++++++++++++++
 tb/tb_tlb_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ctrl_if.sv
// Command/response bundle between the CPU control path and the TLB maintenance sequencer.
// The CPU side is the master; tlb_ctrl is the slave.
interface tlb_ctrl_if #(
  parameter int INDEX_W = 5
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [INDEX_W-1:0] cmd_index;
  logic [19:0]        cmd_page;
  logic [19:0]        cmd_frame;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_miss;
  logic [INDEX_W-1:0] rsp_index;
  logic [19:0]        rsp_page;
  logic [19:0]        rsp_frame;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_page, cmd_frame, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_miss, rsp_index, rsp_page, rsp_frame
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_page, cmd_frame, rsp_ready,
    output cmd_ready, rsp_valid, rsp_miss, rsp_index, rsp_page, rsp_frame
  );
endinterface

// File: rtl/tlb_ctrl.sv
// Sequencer for the TLB maintenance port: probe, indexed read, indexed write and random write.
// Owns the random-replacement counter and freezes fetch-side translation while a write is in flight.
module tlb_ctrl #(
  parameter int NUM_ENTRIES   = 32,
  parameter int FIXED_ENTRIES = 4,
  parameter int INDEX_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  tlb_ctrl_if.slave          bus,
  output logic [19:0]        tlb_probe_page,
  output logic [INDEX_W-1:0] tlb_rw_index,
  output logic               tlb_w_enable,
  output logic [19:0]        tlb_w_page,
  output logic [19:0]        tlb_w_frame,
  input  logic               tlb_miss,
  input  logic [INDEX_W-1:0] tlb_found,
  input  logic [19:0]        tlb_r_page,
  input  logic [19:0]        tlb_r_frame,
  output logic               xlat_lock
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  localparam logic [1:0] OP_PROBE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_WR_RAND = 2'b11;

  localparam logic [INDEX_W-1:0] RAND_MAX = INDEX_W'(NUM_ENTRIES - 1);
  localparam logic [INDEX_W-1:0] RAND_MIN = INDEX_W'(FIXED_ENTRIES);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [INDEX_W-1:0] rand_q, rand_d;
  logic [INDEX_W-1:0] rw_index_q, rw_index_d;
  logic [19:0]        probe_page_q, probe_page_d;
  logic [19:0]        w_page_q, w_page_d;
  logic [19:0]        w_frame_q, w_frame_d;
  logic               w_enable_q, w_enable_d;
  logic               xlat_lock_q, xlat_lock_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_miss_q, rsp_miss_d;
  logic [INDEX_W-1:0] rsp_index_q, rsp_index_d;
  logic [19:0]        rsp_page_q, rsp_page_d;
  logic [19:0]        rsp_frame_q, rsp_frame_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rw_index_d   = rw_index_q;
    probe_page_d = probe_page_q;
    w_page_d     = w_page_q;
    w_frame_d    = w_frame_q;
    w_enable_d   = w_enable_q;
    xlat_lock_d  = xlat_lock_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_miss_d   = rsp_miss_q;
    rsp_index_d  = rsp_index_q;
    rsp_page_d   = rsp_page_q;
    rsp_frame_d  = rsp_frame_q;

    // Free-running victim pointer; the low FIXED_ENTRIES slots are never produced.
    rand_d = (rand_q == RAND_MIN) ? RAND_MAX : rand_q - INDEX_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d         = bus.cmd_op;
          rw_index_d   = (bus.cmd_op == OP_WR_RAND) ? rand_q : bus.cmd_index;
          probe_page_d = bus.cmd_page;
          w_page_d     = bus.cmd_page;
          w_frame_d    = bus.cmd_frame;
          w_enable_d   = bus.cmd_op[1];
          xlat_lock_d  = bus.cmd_op[1];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        w_enable_d  = 1'b0;
        rsp_miss_d  = (op_q == OP_PROBE) && tlb_miss;
        rsp_index_d = (op_q != OP_PROBE) ? rw_index_q :
                      (tlb_miss ? '0 : tlb_found);
        rsp_page_d  = '0;
        rsp_frame_d = '0;
        state_d     = CAPT;
      end
      CAPT: begin
        // TLB read data is registered, so it only becomes valid one cycle after rw_index.
        if (op_q == OP_READ) begin
          rsp_page_d  = tlb_r_page;
          rsp_frame_d = tlb_r_frame;
        end
        xlat_lock_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_PROBE;
      rand_q       <= RAND_MAX;
      rw_index_q   <= '0;
      probe_page_q <= '0;
      w_page_q     <= '0;
      w_frame_q    <= '0;
      w_enable_q   <= 1'b0;
      xlat_lock_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_miss_q   <= 1'b0;
      rsp_index_q  <= '0;
      rsp_page_q   <= '0;
      rsp_frame_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rand_q       <= rand_d;
      rw_index_q   <= rw_index_d;
      probe_page_q <= probe_page_d;
      w_page_q     <= w_page_d;
      w_frame_q    <= w_frame_d;
      w_enable_q   <= w_enable_d;
      xlat_lock_q  <= xlat_lock_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_miss_q   <= rsp_miss_d;
      rsp_index_q  <= rsp_index_d;
      rsp_page_q   <= rsp_page_d;
      rsp_frame_q  <= rsp_frame_d;
    end
  end

  // Gating with rst drops a write whose EXEC cycle coincides with reset.
  assign tlb_w_enable   = w_enable_q & ~rst;
  assign tlb_rw_index   = rw_index_q;
  assign tlb_probe_page = probe_page_q;
  assign tlb_w_page     = w_page_q;
  assign tlb_w_frame    = w_frame_q;
  assign xlat_lock      = xlat_lock_q;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_miss  = rsp_miss_q;
  assign bus.rsp_index = rsp_index_q;
  assign bus.rsp_page  = rsp_page_q;
  assign bus.rsp_frame = rsp_frame_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomized bench for tlb_ctrl: a behavioural TLB array sits on the pins, and a
// transaction-level reference table predicts every response.
module tb_tlb_ctrl;
  localparam int N     = 32;
  localparam int FIXED = 4;
  localparam int IW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_ctrl_if #(.INDEX_W(IW)) bus ();

  logic [19:0]   tlb_probe_page, tlb_w_page, tlb_w_frame, tlb_r_page, tlb_r_frame;
  logic [IW-1:0] tlb_rw_index, tlb_found;
  logic          tlb_w_enable, tlb_miss, xlat_lock;

  tlb_ctrl #(.NUM_ENTRIES(N), .FIXED_ENTRIES(FIXED), .INDEX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tlb_probe_page(tlb_probe_page),
    .tlb_rw_index(tlb_rw_index),
    .tlb_w_enable(tlb_w_enable),
    .tlb_w_page(tlb_w_page),
    .tlb_w_frame(tlb_w_frame),
    .tlb_miss(tlb_miss),
    .tlb_found(tlb_found),
    .tlb_r_page(tlb_r_page),
    .tlb_r_frame(tlb_r_frame),
    .xlat_lock(xlat_lock)
  );

  // Behavioural TLB on the pins: combinational probe, registered read, write on w_enable.
  logic [19:0] env_page [N];
  logic [19:0] env_frame[N];
  logic        env_valid[N];
  logic        env_init = 1'b0;
  int          we_seen  = 0;

  always_comb begin
    tlb_miss  = 1'b1;
    tlb_found = IW'(13);
    for (int i = N - 1; i >= 0; i--)
      if (env_valid[i] && env_page[i] == tlb_probe_page) begin
        tlb_miss  = 1'b0;
        tlb_found = IW'(i);
      end
  end

  always @(posedge clk) begin
    tlb_r_page  <= env_page[tlb_rw_index];
    tlb_r_frame <= env_frame[tlb_rw_index];
    if (!env_init) begin
      for (int i = 0; i < N; i++) begin
        env_valid[i] <= 1'b0;
        env_page[i]  <= '0;
        env_frame[i] <= '0;
      end
      env_init <= 1'b1;
    end else if (tlb_w_enable) begin
      env_valid[tlb_rw_index] <= 1'b1;
      env_page[tlb_rw_index]  <= tlb_w_page;
      env_frame[tlb_rw_index] <= tlb_w_frame;
    end
    if (tlb_w_enable) we_seen <= we_seen + 1;
  end

  // Cycles since the last reset edge give the expected random pointer directly.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [IW-1:0] model_rand();
    return IW'((N - 1) - (cyc % (N - FIXED)));
  endfunction

  logic [19:0] ref_page [N];
  logic [19:0] ref_frame[N];
  bit          ref_valid[N];
  int          exp_we = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
    checkOutput("idle_w_enable", tlb_w_enable, 0);
    checkOutput("idle_lock", xlat_lock, 0);
    checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
  endtask

  // Issues one command from a negedge in IDLE and follows it through to the handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [IW-1:0] idx,
                               input logic [19:0] page, input logic [19:0] frame, input int hold);
    logic [IW-1:0] exp_idx;
    logic          exp_miss;
    logic [19:0]   exp_pg, exp_fr;
    logic          wr;
    wr = op[1];
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_index = idx;
    bus.cmd_page  = page;
    bus.cmd_frame = frame;
    checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
    exp_idx  = (op == 2'b11) ? model_rand() : idx;
    exp_miss = 1'b0;
    exp_pg   = '0;
    exp_fr   = '0;
    case (op)
      2'b00: begin
        exp_miss = 1'b1;
        exp_idx  = '0;
        for (int i = N - 1; i >= 0; i--)
          if (ref_valid[i] && ref_page[i] == page) begin
            exp_miss = 1'b0;
            exp_idx  = IW'(i);
          end
      end
      2'b01: begin
        exp_pg = ref_page[idx];
        exp_fr = ref_frame[idx];
      end
      default: begin
        ref_valid[exp_idx] = 1'b1;
        ref_page[exp_idx]  = page;
        ref_frame[exp_idx] = frame;
        exp_we++;
      end
    endcase

    @(negedge clk);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_index = IW'($urandom);
    bus.cmd_page  = 20'($urandom);
    bus.cmd_frame = 20'($urandom);
    checkOutput("cmd_ready_exec", bus.cmd_ready, 0);
    checkOutput("w_enable_exec", tlb_w_enable, wr);
    checkOutput("lock_exec", xlat_lock, wr);
    checkOutput("probe_page", tlb_probe_page, page);
    checkOutput("rsp_valid_exec", bus.rsp_valid, 0);
    if (op != 2'b00) checkOutput("rw_index", tlb_rw_index, exp_idx);
    if (wr) begin
      checkOutput("w_page", tlb_w_page, page);
      checkOutput("w_frame", tlb_w_frame, frame);
    end

    @(negedge clk);
    checkOutput("w_enable_capt", tlb_w_enable, 0);
    checkOutput("lock_capt", xlat_lock, wr);
    checkOutput("rsp_valid_capt", bus.rsp_valid, 0);

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      checkOutput("rsp_valid", bus.rsp_valid, 1);
      checkOutput("cmd_ready_resp", bus.cmd_ready, 0);
      checkOutput("lock_resp", xlat_lock, 0);
      checkOutput("rsp_miss", bus.rsp_miss, exp_miss);
      checkOutput("rsp_index", bus.rsp_index, exp_idx);
      checkOutput("rsp_page", bus.rsp_page, exp_pg);
      checkOutput("rsp_frame", bus.rsp_frame, exp_fr);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid_done", bus.rsp_valid, 0);
    checkOutput("cmd_ready_done", bus.cmd_ready, 1);
  endtask

  task automatic waitRand(input logic [IW-1:0] v);
    int n;
    n = 0;
    bus.cmd_valid = 1'b0;
    while (model_rand() != v && n < 40) begin
      @(negedge clk);
      checkIdle();
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("[TB] FAIL wait_rand: counter %0d never reached %0d", model_rand(), v);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_index = '0;
    bus.cmd_page  = '0;
    bus.cmd_frame = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_valid[i] = 1'b0;
      ref_page[i]  = '0;
      ref_frame[i] = '0;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_miss", bus.rsp_miss, 0);
    checkOutput("rst_rsp_index", bus.rsp_index, 0);
    checkOutput("rst_rsp_page", bus.rsp_page, 0);
    checkOutput("rst_rsp_frame", bus.rsp_frame, 0);
    checkOutput("rst_w_enable", tlb_w_enable, 0);
    checkOutput("rst_lock", xlat_lock, 0);
    checkOutput("rst_rw_index", tlb_rw_index, 0);
    checkOutput("rst_probe_page", tlb_probe_page, 0);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      checkIdle();
    end

    applyStimulus(2'b10, 5'd7, 20'h12345, 20'h0ABCD, 0);
    applyStimulus(2'b01, 5'd7, 20'h0, 20'h0, 0);
    applyStimulus(2'b00, 5'd0, 20'h12345, 20'h0, 0);
    applyStimulus(2'b00, 5'd0, 20'h54321, 20'h0, 0);
    waitRand(5'd4);
    applyStimulus(2'b11, 5'd0, 20'h00777, 20'h00888, 0);
    waitRand(5'd31);
    applyStimulus(2'b11, 5'd0, 20'h00999, 20'h00AAA, 0);
    applyStimulus(2'b01, 5'd4, 20'h0, 20'h0, 0);

    // Backpressure with a second command already pending.
    applyStimulus(2'b01, 5'd7, 20'h0, 20'h0, 5);
    applyStimulus(2'b00, 5'd0, 20'h00777, 20'h0, 0);

    // Reset lands in EXEC of an indexed write: the write must vanish.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_index = 5'd9;
    bus.cmd_page  = 20'h0BEEF;
    bus.cmd_frame = 20'h00001;
    checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_w_enable", tlb_w_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    checkIdle();
    checkOutput("abort_rw_index", tlb_rw_index, 0);
    applyStimulus(2'b00, 5'd0, 20'h0BEEF, 20'h0, 0);
    applyStimulus(2'b01, 5'd9, 20'h0, 20'h0, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkIdle();
      end
      applyStimulus(2'($urandom_range(0, 3)), IW'($urandom), 20'h10 + 20'($urandom_range(0, 7)),
                    20'($urandom), int'($urandom_range(0, 3)));
    end

    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle();
    checkOutput("w_enable_pulses", we_seen, exp_we);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
